// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control for a RISC-V style in-order pipeline: load-use stalls, memory-wait stalls
// with timeout, ID redirect flushes and per-stage valid tracking.
// Optional performance counters are built only with RISCV_PIPE_CTRL_PERF_EN defined.
module riscv_pipe_ctrl #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned RAW    = 5,
    parameter int unsigned MEM_TO = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              fetch_valid,
    input  logic [RAW-1:0]    id_rs1,
    input  logic [RAW-1:0]    id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_redirect,
    input  logic              ex_memread,
    input  logic [RAW-1:0]    ex_rd,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic              bubble,
    output logic [1:0]        state,
    output logic              mem_timeout,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2,
        StErr     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [7:0]        wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [8:0]        wait_inc;
    logic              active, lu_hazard, mem_wait, redirect_flush;

    // Outputs are forced quiet while reset is asserted, not just after it.
    assign active    = EN & ~RST & (state_q != StErr);
    assign lu_hazard = EN & valid_q[0] & valid_q[1] & ex_memread & (ex_rd != '0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign mem_wait  = EN & valid_q[2] & mem_req & ~mem_ready;
    assign redirect_flush = id_redirect & valid_q[0];
    assign wait_inc  = {1'b0, wait_q} + 9'd1;

    always_comb begin
        pc_en     = 1'b0;
        stage_en  = '0;
        bubble    = 1'b0;
        valid_d   = valid_q;
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if (active) begin
            if (mem_wait) begin
                wait_d  = wait_inc[7:0];
                state_d = StMemWait;
                if (wait_inc >= 9'(MEM_TO)) begin
                    state_d   = StErr;
                    timeout_d = 1'b1;
                end
            end else if (lu_hazard) begin
                // Hold IF/ID, drain the rest and squash the ID/EX slot; a coincident
                // redirect is dropped here and seen again once the stall clears.
                wait_d   = '0;
                stage_en = {{(STAGES-1){1'b1}}, 1'b0};
                bubble   = 1'b1;
                valid_d  = {valid_q[STAGES-2:1], 1'b0, valid_q[0]};
                state_d  = StLuStall;
            end else begin
                wait_d   = '0;
                pc_en    = 1'b1;
                stage_en = '1;
                valid_d  = {valid_q[STAGES-2:0], fetch_valid & ~redirect_flush};
                state_d  = StRun;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StRun;
            valid_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign stage_valid = valid_q;
    assign state       = state_q;
    assign mem_timeout = timeout_q;

`ifdef RISCV_PIPE_CTRL_PERF_EN
    logic        stall_evt, flush_evt;
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign stall_evt = active & (mem_wait | lu_hazard);
    assign flush_evt = active & ~mem_wait & ~lu_hazard & redirect_flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed, table-driven bench for riscv_pipe_ctrl (STAGES=5, RAW=5, MEM_TO=15) plus
// hand-written sequences for reset, memory timeout, priority and counters.
module tb_riscv_pipe_ctrl;

`ifdef RISCV_PIPE_CTRL_PERF_EN
    localparam int unsigned PERF = 1;
`else
    localparam int unsigned PERF = 0;
`endif

    logic        CLK, RST, EN, fetch_valid;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, id_redirect, ex_memread, mem_req, mem_ready;
    logic        pc_en, bubble, mem_timeout;
    logic [4:0]  stage_en, stage_valid;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_pipe_ctrl #(
        .STAGES(5),
        .RAW   (5),
        .MEM_TO(15)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .fetch_valid(fetch_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_redirect(id_redirect),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .stage_en   (stage_en),
        .stage_valid(stage_valid),
        .bubble     (bubble),
        .state      (state),
        .mem_timeout(mem_timeout),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       en, fv;
        logic [4:0] rs1, rs2;
        logic       u1, u2, rdr, mr;
        logic [4:0] rd;
        logic       mq, my;
        logic       pc;
        logic [4:0] se;
        logic       bub;
        logic [4:0] vld;
        logic [1:0] st;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic en, input logic fv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic rdr, input logic mr, input logic [4:0] rd,
                                input logic mq, input logic my, input logic pc,
                                input logic [4:0] se, input logic bub, input logic [4:0] vld,
                                input logic [1:0] st);
        vec_t v;
        v.en = en;   v.fv = fv;   v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1;   v.u2 = u2;   v.rdr = rdr; v.mr = mr;
        v.rd = rd;   v.mq = mq;   v.my = my;   v.pc = pc;
        v.se = se;   v.bub = bub; v.vld = vld; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input vec_t v);
        EN = v.en;          fetch_valid = v.fv;
        id_rs1 = v.rs1;     id_rs2 = v.rs2;
        id_use_rs1 = v.u1;  id_use_rs2 = v.u2;
        id_redirect = v.rdr;
        ex_memread = v.mr;  ex_rd = v.rd;
        mem_req = v.mq;     mem_ready = v.my;
    endtask

    task automatic idle_in();
        EN = 1'b1; fetch_valid = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_redirect = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // en fv rs1 rs2 u1 u2 rdr mr rd mq my | pc se bub vld st
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b00001, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b00011, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b00111, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b01111, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b11111, 0));
        vq.push_back(mk(1, 0, 5, 0, 1, 0, 0, 1, 5, 0, 0, 0, 5'b11110, 1, 5'b11101, 1));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b11011, 0));
        vq.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 5'b11111, 0, 5'b10111, 0));
        vq.push_back(mk(1, 1, 7, 3, 1, 1, 0, 1, 3, 0, 0, 0, 5'b11110, 1, 5'b01101, 1));
        vq.push_back(mk(1, 0, 7, 3, 1, 1, 0, 1, 3, 0, 0, 1, 5'b11111, 0, 5'b11010, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b10101, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b01011, 0));
        vq.push_back(mk(1, 1, 9, 3, 1, 0, 0, 1, 3, 0, 0, 1, 5'b11111, 0, 5'b10111, 0));
        vq.push_back(mk(0, 1, 5, 0, 1, 0, 0, 1, 5, 0, 0, 0, 5'b00000, 0, 5'b10111, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 5'b10111, 2));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 5'b10111, 2));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 5'b10111, 2));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11111, 0, 5'b01110, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b11101, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b11010, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b10101, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b01011, 0));
        vq.push_back(mk(1, 1, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 5'b11110, 1, 5'b10101, 1));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5'b11111, 0, 5'b01010, 0));

        // Reset with EN/fetch active: outputs must stay quiet.
        idle_in();
        RST = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_stage_en", 32'(stage_en), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_valid", 32'(stage_valid), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        step();
        RST = 1'b0;

        foreach (vq[i]) begin
            set_in(vq[i]);
            #1;
            chk($sformatf("v%0d_pc_en", i), 32'(pc_en), 32'(vq[i].pc));
            chk($sformatf("v%0d_stage_en", i), 32'(stage_en), 32'(vq[i].se));
            chk($sformatf("v%0d_bubble", i), 32'(bubble), 32'(vq[i].bub));
            step();
            chk($sformatf("v%0d_valid", i), 32'(stage_valid), 32'(vq[i].vld));
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vq[i].st));
        end
        chk("tbl_stall_cnt", stall_cnt, 32'(6 * PERF));
        chk("tbl_flush_cnt", flush_cnt, 32'(2 * PERF));

        // Reset in the middle of a memory wait discards it.
        idle_in();
        RST = 1'b1;
        step();
        RST = 1'b0;
        step(); step(); step();
        mem_req = 1'b1;
        step(); step();
        chk("mw_state", 32'(state), 32'd2);
        RST = 1'b1;
        #1;
        chk("midrst_pc_en", 32'(pc_en), 32'd0);
        chk("midrst_stage_en", 32'(stage_en), 32'd0);
        chk("midrst_valid", 32'(stage_valid), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        step();
        RST = 1'b0;
        #1;
        chk("postrst_pc_en", 32'(pc_en), 32'd1);
        step();
        chk("postrst_valid", 32'(stage_valid), 32'b00001);

        // Timeout after exactly MEM_TO wait cycles, no leftover count from before reset.
        mem_req = 1'b0;
        step(); step();
        chk("to_fill_valid", 32'(stage_valid), 32'b00111);
        mem_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("to_state_%0d", i), 32'(state), (i < 15) ? 32'd2 : 32'd3);
            chk($sformatf("to_flag_%0d", i), 32'(mem_timeout), (i < 15) ? 32'd0 : 32'd1);
        end
        mem_ready = 1'b1;
        #1;
        chk("err_pc_en", 32'(pc_en), 32'd0);
        chk("err_stage_en", 32'(stage_en), 32'd0);
        step(); step(); step();
        chk("err_state_hold", 32'(state), 32'd3);
        chk("err_flag_hold", 32'(mem_timeout), 32'd1);
        chk("err_valid_hold", 32'(stage_valid), 32'b00111);
        RST = 1'b1;
        #1;
        chk("err_rst_state", 32'(state), 32'd0);
        chk("err_rst_flag", 32'(mem_timeout), 32'd0);
        step();
        RST = 1'b0;

        // mem_wait outranks lu_hazard; then counters for one stall episode and one flush.
        idle_in();
        step(); step(); step();
        mem_req = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        chk("prio_pc_en", 32'(pc_en), 32'd0);
        chk("prio_stage_en", 32'(stage_en), 32'd0);
        chk("prio_bubble", 32'(bubble), 32'd0);
        step();
        chk("prio_state", 32'(state), 32'd2);
        chk("prio_valid", 32'(stage_valid), 32'b00111);
        ex_memread = 1'b0;
        step(); step();
        mem_ready = 1'b1;
        #1;
        chk("mw_release_pc_en", 32'(pc_en), 32'd1);
        step();
        chk("mw_release_state", 32'(state), 32'd0);
        chk("mw_release_valid", 32'(stage_valid), 32'b01111);
        chk("mw_stall_cnt", stall_cnt, 32'(3 * PERF));
        mem_req = 1'b0; id_redirect = 1'b1;
        step();
        chk("flush_valid", 32'(stage_valid), 32'b11110);
        chk("flush_cnt", flush_cnt, 32'(PERF));
        chk("flush_stall_cnt", stall_cnt, 32'(3 * PERF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
